// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam int NIBBLE_W = 4;

  // The timer must hold the larger reload value; never narrower than one bit.
  function automatic int cnt_width(input int refresh_div, input int blank_cycles);
    int m;
    m = 2;
    if (refresh_div > m) m = refresh_div;
    if (blank_cycles > m) m = blank_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Valid/ready load channel carrying one full display word (one nibble per digit).
interface display_scan_ctrl_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                           load_valid;
  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data;
  logic                           load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module scan_timer #(
  parameter int           W         = 2,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload wins; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared hex decoder, with a
// blanking gap before each digit and frame-aligned commit of new display words.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_scan_ctrl_if.slave    load_if,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NIBBLE_W-1:0]   nibble_out,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_tick
);

  localparam int WORD_W = NIBBLE_W * NUM_DIGITS;
  localparam int CNT_W  = cnt_width(REFRESH_DIV, BLANK_CYCLES);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [WORD_W-1:0] active_q, active_d;
  logic [WORD_W-1:0] pending_q, pending_d;
  logic              ready_q, ready_d;

  logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  tick_q, tick_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             frame_end;
  logic             accept;
  logic             commit;
  logic [NUM_DIGITS-1:0] lit;
`ifdef DISPLAY_SCAN_LZB_EN
  logic seen;
`endif

  // Reset value matches the BLANK reload so the first digit after reset gets a full gap.
  scan_timer #(
    .W         (CNT_W),
    .RESET_VAL (BLANK_LOAD)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // FSM state and digit index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: leave each phase on terminal count and reload the timer for the next one.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    tmr_val   = BLANK_LOAD;
    frame_end = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (tmr_tc) begin
          state_d  = SHOW;
          tmr_load = 1'b1;
          tmr_val  = SHOW_LOAD;
        end
      end
      SHOW: begin
        if (tmr_tc) begin
          tmr_load  = 1'b1;
          frame_end = (idx_q == LAST_IDX);
          idx_d     = frame_end ? '0 : idx_q + IDX_W'(1);
          if (BLANK_CYCLES == 0) begin
            state_d = SHOW;
            tmr_val = SHOW_LOAD;
          end else begin
            state_d = BLANK;
            tmr_val = BLANK_LOAD;
          end
        end
      end
      default: begin
        state_d = BLANK;
      end
    endcase
  end

  // Double buffer: accept into pending when empty, promote to active only at frame end.
  always_comb begin
    accept    = load_if.load_valid & ready_q;
    commit    = frame_end & ~ready_q;
    active_d  = commit ? pending_q : active_q;
    pending_d = accept ? load_if.load_data : pending_q;
    ready_d   = ready_q;
    if (accept) begin
      ready_d = 1'b0;
    end else if (commit) begin
      ready_d = 1'b1;
    end
  end

  // Outputs derived from next-state values so the registered outputs line up with the state.
  always_comb begin
    lit = '1;
`ifdef DISPLAY_SCAN_LZB_EN
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      seen   = seen | (active_d[k*NIBBLE_W +: NIBBLE_W] != '0);
      lit[k] = seen;
    end
`endif
    an_n_d   = '1;
    nibble_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nibble_d = active_d[k*NIBBLE_W +: NIBBLE_W];
        if (state_d == SHOW) begin
          an_n_d[k] = ~(digit_en[k] & lit[k]);
        end
      end
    end
    tick_d = frame_end;
  end

  // Buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '0;
      pending_q <= '0;
      ready_q   <= 1'b1;
      nibble_q  <= '0;
      an_n_q    <= '1;
      tick_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      nibble_q  <= nibble_d;
      an_n_q    <= an_n_d;
      tick_q    <= tick_d;
    end
  end

  assign load_if.load_ready = ready_q;
  assign nibble_out         = nibble_q;
  assign an_n               = an_n_q;
  assign frame_tick         = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: 4 digits, 4-cycle show, 2-cycle blank.
// Expected frame words are queued as stimulus is driven and popped per displayed frame.
module tb_display_scan_ctrl;
  import display_pkg::*;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int DP    = RD + BC;
  localparam int FRAME = ND * DP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] digit_en;
  logic [3:0]    nibble_out;
  logic [ND-1:0] an_n;
  logic          frame_tick;

  int tests = 0;
  int fails = 0;
  logic [15:0] expq[$];

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_if    (lif),
    .digit_en   (digit_en),
    .nibble_out (nibble_out),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Expected anodes at frame offset o: blank for the first BC cycles of each digit slot.
  function automatic logic [3:0] exp_an(logic [15:0] w, int o, logic [3:0] en);
    int d;
    logic [3:0] r;
    logic on;
    d = o / DP;
    r = 4'hF;
    if ((o % DP) >= BC) begin
      on = en[d];
`ifdef DISPLAY_SCAN_LZB_EN
      if (d > 0 && (w >> (4 * d)) == 16'h0) on = 1'b0;
`endif
      if (on) r[d] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_nib(logic [15:0] w, int o);
    logic [15:0] t;
    t = w >> (4 * (o / DP));
    return t[3:0];
  endfunction

  task automatic wait_tick(string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 3 * FRAME);
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s wait_tick: frame_tick got %b want 1 within %0d cycles", name, frame_tick, n);
    end
  endtask

  // Starts on the frame_tick cycle, ends on the next one.
  task automatic check_frame(string name, logic [3:0] en);
    logic [15:0] w;
    w = 16'h0;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s scoreboard: queue size got 0 want >0", name);
    end else begin
      w = expq.pop_front();
    end
    for (int o = 0; o < FRAME; o++) begin
      if (o > 0) @(negedge clk);
      tests++;
      if (an_n !== exp_an(w, o, en)) begin
        fails++;
        $display("[TB] FAIL %s an_n o=%0d: got %b want %b", name, o, an_n, exp_an(w, o, en));
      end
      tests++;
      if (nibble_out !== exp_nib(w, o)) begin
        fails++;
        $display("[TB] FAIL %s nibble o=%0d: got %h want %h", name, o, nibble_out, exp_nib(w, o));
      end
      tests++;
      if (frame_tick !== (o == 0)) begin
        fails++;
        $display("[TB] FAIL %s frame_tick o=%0d: got %b want %b", name, o, frame_tick, (o == 0));
      end
    end
    @(negedge clk);
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s tick_spacing: frame_tick got %b want 1", name, frame_tick);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (an_n !== 4'hF) begin fails++; $display("[TB] FAIL rst_an_n: got %b want 1111", an_n); end
    tests++;
    if (nibble_out !== 4'h0) begin fails++; $display("[TB] FAIL rst_nibble: got %h want 0", nibble_out); end
    tests++;
    if (frame_tick !== 1'b0) begin fails++; $display("[TB] FAIL rst_tick: got %b want 0", frame_tick); end
    tests++;
    if (lif.load_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_ready: got %b want 1", lif.load_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (an_n !== 4'hF) begin fails++; $display("[TB] FAIL rst_release_an_n: got %b want 1111", an_n); end
  endtask

  task automatic test_load();
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h4321;
    expq.push_back(16'h4321);
    @(negedge clk);
    lif.load_valid = 1'b0;
    tests++;
    if (lif.load_ready !== 1'b0) begin fails++; $display("[TB] FAIL load_ready_fall: got %b want 0", lif.load_ready); end
    wait_tick("load");
    tests++;
    if (lif.load_ready !== 1'b1) begin fails++; $display("[TB] FAIL load_ready_rise: got %b want 1", lif.load_ready); end
    check_frame("load_4321", 4'hF);
  endtask

  task automatic test_back_to_back();
    int n;
    expq.push_back(16'h4321);
    expq.push_back(16'hAAAA);
    expq.push_back(16'hBBBB);
    fork
      begin
        check_frame("b2b_old", 4'hF);
        check_frame("b2b_aaaa", 4'hF);
        check_frame("b2b_bbbb", 4'hF);
      end
      begin
        lif.load_valid = 1'b1;
        lif.load_data  = 16'hAAAA;
        @(negedge clk);
        lif.load_data  = 16'hBBBB;
        tests++;
        if (lif.load_ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_ready_low: got %b want 0", lif.load_ready); end
        n = 0;
        while (lif.load_ready !== 1'b1 && n < 2 * FRAME) begin
          @(negedge clk);
          n++;
        end
        tests++;
        if (lif.load_ready !== 1'b1 || frame_tick !== 1'b1) begin
          fails++;
          $display("[TB] FAIL b2b_ready_at_tick: ready/tick got %b/%b want 1/1", lif.load_ready, frame_tick);
        end
        @(negedge clk);
        lif.load_valid = 1'b0;
      end
    join
  endtask

  task automatic test_boundary_load();
    expq.push_back(16'hBBBB);
    expq.push_back(16'hBBBB);
    expq.push_back(16'hCCCC);
    fork
      begin
        check_frame("bnd_cur", 4'hF);
        check_frame("bnd_held", 4'hF);
        check_frame("bnd_cccc", 4'hF);
      end
      begin
        repeat (FRAME - 1) @(negedge clk);
        tests++;
        if (lif.load_ready !== 1'b1) begin fails++; $display("[TB] FAIL bnd_ready_before: got %b want 1", lif.load_ready); end
        lif.load_valid = 1'b1;
        lif.load_data  = 16'hCCCC;
        @(negedge clk);
        lif.load_valid = 1'b0;
        tests++;
        if (lif.load_ready !== 1'b0 || frame_tick !== 1'b1) begin
          fails++;
          $display("[TB] FAIL bnd_ready_after: ready/tick got %b/%b want 0/1", lif.load_ready, frame_tick);
        end
      end
    join
  endtask

  task automatic test_digit_en();
    digit_en = 4'b0101;
    expq.push_back(16'hCCCC);
    check_frame("en_0101", 4'b0101);
    digit_en = 4'b0000;
    expq.push_back(16'hCCCC);
    check_frame("en_none", 4'b0000);
    digit_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    int n;
    lif.load_valid = 1'b1;
    lif.load_data  = 16'hDDDD;
    @(negedge clk);
    lif.load_valid = 1'b0;
    repeat (14) @(negedge clk);
    tests++;
    if (an_n !== 4'b1011 || nibble_out !== 4'hC) begin
      fails++;
      $display("[TB] FAIL mid_show_d2: an_n/nibble got %b/%h want 1011/c", an_n, nibble_out);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (an_n !== 4'hF) begin fails++; $display("[TB] FAIL mid_rst_an_n: got %b want 1111", an_n); end
    tests++;
    if (nibble_out !== 4'h0) begin fails++; $display("[TB] FAIL mid_rst_nibble: got %h want 0", nibble_out); end
    tests++;
    if (lif.load_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_rst_ready: got %b want 1", lif.load_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (an_n !== 4'hF) begin fails++; $display("[TB] FAIL mid_rel_blank: got %b want 1111", an_n); end
    n = 0;
    while (an_n === 4'hF && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (an_n !== 4'b1110 || nibble_out !== 4'h0) begin
      fails++;
      $display("[TB] FAIL mid_restart_d0: an_n/nibble got %b/%h want 1110/0", an_n, nibble_out);
    end
    expq.push_back(16'h0000);
    wait_tick("post_reset");
    check_frame("post_reset_0000", 4'hF);
  endtask

  task automatic test_lzb();
    expq.push_back(16'h0000);
    expq.push_back(16'h0050);
    fork
      begin
        check_frame("lzb_prev", 4'hF);
        check_frame("lzb_0050", 4'hF);
      end
      begin
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h0050;
        @(negedge clk);
        lif.load_valid = 1'b0;
      end
    join
  endtask

  // Test sequence.
  initial begin
    rst_n          = 1'b0;
    digit_en       = 4'hF;
    lif.load_valid = 1'b0;
    lif.load_data  = 16'h0;
    test_reset();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_digit_en();
    test_reset_mid();
    test_lzb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Holds a double-buffered digit word and presents one nibble at a time on nibble_out, which feeds the decoder's 4-bit input.
- Asserts the matching active-low anode with a blanking gap between digits to suppress ghosting.
- Accepts new display words through a valid/ready handshake and commits them only at frame boundaries, so no frame is ever torn.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- REFRESH_DIV, 50000, clk cycles each digit is driven in SHOW (>=1).
- BLANK_CYCLES, 500, clk cycles all anodes are off before each digit (>=0; 0 skips BLANK).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  producer offers load_data.
- load_data  in  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant, in bits [3:0].
- load_ready  out  1  pending buffer empty; a handshake completes when load_valid && load_ready.
- digit_en  in  NUM_DIGITS  per-digit enable, sampled live; 0 keeps that anode off.
- nibble_out  out  4  nibble to decoder input.
- an_n  out  NUM_DIGITS  active-low anode selects.
- frame_tick  out  1  one-cycle pulse at each frame end.

Behaviour:
- Reset (async assert, sync release): an_n = all 1, nibble_out = 0, frame_tick = 0, load_ready = 1, active buffer = 0, pending buffer empty, idx = 0, state = BLANK, cnt = 0.
- All outputs are registered.
- FSM states are BLANK and SHOW.
- BLANK:
  - an_n = all 1 and nibble_out = active[idx].
  - Stays BLANK_CYCLES cycles, then goes to SHOW with cnt = 0.
  - If BLANK_CYCLES = 0, the block goes directly to SHOW.
- SHOW:
  - an_n[idx] = ~digit_en[idx]; all other anodes = 1; nibble_out = active[idx].
  - Stays REFRESH_DIV cycles.
  - On the last cycle: idx = (idx+1) mod NUM_DIGITS, state = BLANK, cnt = 0.
- Digit period = BLANK_CYCLES + REFRESH_DIV. Frame period = NUM_DIGITS × digit period.
- Frame boundary is the last SHOW cycle of idx = NUM_DIGITS-1. On the following edge:
  - frame_tick = 1 for exactly one cycle.
  - idx wraps to 0.
  - If pending is full: active <= pending, pending emptied, load_ready = 1 from the next cycle.
- Handshake:
  - On accept, pending <= load_data, and load_ready drops to 0 on the next edge.
  - load_ready stays 0 until the next frame boundary.
  - load_data is ignored while load_ready = 0.
- Boundary cases:
  - Handshake on the frame-boundary cycle with pending empty: data goes to pending and commits at the next boundary, not this one.
  - digit_en all 0: timing continues unchanged, an_n stays all 1, frame_tick still pulses.
  - Reset mid-frame: returns to the reset state immediately; pending data is lost.
- Counter width = $clog2(max(REFRESH_DIV, BLANK_CYCLES, 2)). Wrap is by compare-equal, never by overflow.

Optional Feature:
- Macro: DISPLAY_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During SHOW, a digit k > 0 keeps its anode at 1 when active[k] and every higher nibble of active are 0.
  - Digit 0 is always shown.
  - Evaluated on the committed (active) buffer only.
- Undefined: all enabled digits are shown, zeros included.
- Timing is identical in both builds.

Decomposition:
- Package display_pkg holds:
  - the state typedef (BLANK, SHOW);
  - NIBBLE_W = 4;
  - a function computing counter width from the parameters.
- One sub-module, scan_timer:
  - a loadable down-counter with a terminal-count output;
  - instantiated once and reloaded with BLANK_CYCLES-1 or REFRESH_DIV-1 on each state entry.
- The decoder itself is instantiated outside this block.

Test Plan:
- All cases use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, giving a 24-cycle frame.
- Reset then load 16'h4321, digit_en=4'hF:
  - load_ready falls to 0 next cycle.
  - After the first frame_tick, an_n cycles 1110, 1101, 1011, 0111, each for 4 cycles with 2 all-ones cycles between.
  - nibble_out reads 1, 2, 3, 4.
- Back-to-back loads 16'hAAAA then 16'hBBBB:
  - The second load waits with ready=0 until the frame_tick.
  - The display shows AAAA for a full frame before BBBB.
  - No mixed-digit frame appears.
- Load asserted exactly on the frame-boundary cycle with pending empty:
  - Data is not displayed until after the second frame_tick.
- digit_en = 4'b0101:
  - an_n[1] and an_n[3] stay 1 throughout.
  - Period and frame_tick spacing stay at 24 cycles.
- rst_n pulled low mid-SHOW of digit 2:
  - an_n = 1111, nibble_out = 0, load_ready = 1 in the same cycle.
  - After release, scanning restarts at digit 0 with BLANK.
- With DISPLAY_SCAN_LZB_EN, load 16'h0050:
  - Digits 3 and 2 stay dark; digits 1 ("5") and 0 ("0") are lit.
  - Without the macro, all four digits are lit.
